datapath_unit: RTL

Execution-side responder to the control unit. It consumes the CU's operand1/operand2/offset/opcode/sel1/sel3/w_r, performs the ALU operation, and accesses a 2^ADDR_BITS x DATA_WIDTH data memory. It returns result2 for register write-back. It sits between the CU and the write-back path, and owns data-memory initialisation after reset.

---
 rtl/dp_pkg.sv | 32 +++
 rtl/dp_alu.sv | 59 +++++
 rtl/datapath_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared types and constants for the datapath unit: ALU opcodes, FSM states and
// default sizes.
package dp_pkg;

  localparam int DP_DATA_WIDTH = 8;
  localparam int DP_ADDR_BITS  = 5;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_INC   = 4'h8,
    OP_DEC   = 4'h9,
    OP_PASSA = 4'hA,
    OP_PASSB = 4'hB,
    OP_EQ    = 4'hC,
    OP_LTU   = 4'hD,
    OP_MUL   = 4'hE,
    OP_NOP   = 4'hF
  } alu_op_e;

  typedef enum logic {
    DP_INIT  = 1'b0,
    DP_READY = 1'b1
  } dp_state_e;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the datapath unit. The carry output exists only when
// DP_FLAGS_EN is defined.
module dp_alu
  import dp_pkg::*;
#(
  parameter int W = DP_DATA_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] result
`ifdef DP_FLAGS_EN
  ,
  output logic         carry
`endif
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT:   result = ~a;
      OP_SHL:   result = {a[W-2:0], 1'b0};
      OP_SHR:   result = {1'b0, a[W-1:1]};
      OP_INC:   result = a + W'(1);
      OP_DEC:   result = a - W'(1);
      OP_PASSA: result = a;
      OP_PASSB: result = b;
      OP_EQ:    result = {{(W-1){1'b0}}, (a == b)};
      OP_LTU:   result = {{(W-1){1'b0}}, (a < b)};
      OP_MUL:   result = a * b;
      default:  result = '0;
    endcase
  end

`ifdef DP_FLAGS_EN
  logic [W-1:0] sum;
  assign sum = a + b;

  // A wrapped sum is smaller than either addend exactly when the add carried out.
  always_comb begin
    carry = 1'b0;
    case (op)
      OP_ADD:  carry = (sum < a);
      OP_SUB:  carry = (a < b);
      OP_INC:  carry = &a;
      OP_DEC:  carry = ~|a;
      OP_SHL:  carry = a[W-1];
      OP_SHR:  carry = a[0];
      default: carry = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/datapath_unit.sv
// Datapath unit: ALU, data memory with post-reset zeroing, and write-back mux.
// Define DP_FLAGS_EN to add the registered {N,C,Z} flags output.
module datapath_unit
  import dp_pkg::*;
#(
  parameter int DATA_WIDTH = DP_DATA_WIDTH,
  parameter int ADDR_BITS  = DP_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  ready,
  output dp_state_e             dbg_state
`ifdef DP_FLAGS_EN
  ,
  output logic [2:0]            flags
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // ready is a level status, not a handshake: once high, every edge consumes
  // the presented operation and result2 reflects it one edge later.
  dp_state_e state, state_nxt;
  logic [ADDR_BITS-1:0]  cnt;
  logic [ADDR_BITS-1:0]  addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] alu_b, alu_res, alu_q, mem_q;
  alu_op_e               op;

  assign op    = alu_op_e'(opcode);
  assign alu_b = sel3 ? offset : operand2;
  // Only the low address bits matter, so the wrap falls out of the narrow add.
  assign addr  = operand1[ADDR_BITS-1:0] + offset[ADDR_BITS-1:0];

`ifdef DP_FLAGS_EN
  logic alu_carry;
  dp_alu #(.W(DATA_WIDTH)) u_alu (
    .a      (operand1),
    .b      (alu_b),
    .op     (op),
    .result (alu_res),
    .carry  (alu_carry)
  );
`else
  dp_alu #(.W(DATA_WIDTH)) u_alu (
    .a      (operand1),
    .b      (alu_b),
    .op     (op),
    .result (alu_res)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= DP_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DP_INIT:  if (&cnt) state_nxt = DP_READY;
      DP_READY: state_nxt = DP_READY;
      default:  state_nxt = DP_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (state == DP_INIT) cnt <= cnt + ADDR_BITS'(1);
  end

  // Memory has no reset; the INIT sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == DP_INIT)            mem[cnt]  <= '0;
      else if (state == DP_READY && w_r) mem[addr] <= operand2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q <= '0;
      mem_q <= '0;
    end else if (state == DP_READY) begin
      if (op != OP_NOP) alu_q <= alu_res;
      mem_q <= w_r ? operand2 : mem[addr];
    end
  end

`ifdef DP_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst)
      flags <= 3'b000;
    else if (state == DP_READY && op != OP_NOP)
      flags <= {alu_res[DATA_WIDTH-1], alu_carry, (alu_res == '0)};
  end
`endif

  assign result2   = sel1 ? alu_q : mem_q;
  assign ready     = (state == DP_READY);
  assign dbg_state = state;

endmodule
